// File: rtl/min_cost_scanner_if.sv
// Bundles the queue read/pop port, the winner handshake and the status flags
// of the min-cost scanner.
interface min_cost_scanner_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] q_addr;
  logic [DATA_WIDTH-1:0] q_data;
  logic                  q_write_en;
  logic [DATA_WIDTH-1:0] q_wdata;
  logic                  best_valid;
  logic                  best_ready;
  logic [ADDR_WIDTH-1:0] best_addr;
  logic [DATA_WIDTH-1:0] best_cost;
  logic                  empty;
  logic                  busy;

  modport slave (
    input  start, q_data, best_ready,
    output q_addr, q_write_en, q_wdata, best_valid, best_addr, best_cost,
           empty, busy
  );

  modport master (
    output start, q_data, best_ready,
    input  q_addr, q_write_en, q_wdata, best_valid, best_addr, best_cost,
           empty, busy
  );
endinterface

// File: rtl/min_cost_scanner.sv
// Scans every open-list queue slot for the lowest cost, offers the winner on a
// valid/ready handshake and then pops it by writing EMPTY back to its slot.
module min_cost_scanner #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  min_cost_scanner_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] EMPTY     = '1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    OFFER,
    POP
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] q_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] min_q;
  logic [ADDR_WIDTH-1:0] min_addr_q;
  logic                  best_valid_q;
  logic [ADDR_WIDTH-1:0] best_addr_q;
  logic [DATA_WIDTH-1:0] best_cost_q;
  logic                  q_we_q;
  logic                  empty_q;
  logic                  busy_q;

  logic                  take_d;
  logic [DATA_WIDTH-1:0] min_d;
  logic [ADDR_WIDTH-1:0] min_addr_d;

  // rd_addr_q/rd_vld_q trail q_addr by one edge so q_data is paired with the
  // slot that produced it; strict less-than keeps the lowest address on ties.
  always_comb begin
    take_d     = 1'b0;
    min_d      = min_q;
    min_addr_d = min_addr_q;
    if (rd_vld_q && (bus.q_data < min_q)) begin
      take_d     = 1'b1;
      min_d      = bus.q_data;
      min_addr_d = rd_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      q_addr_q     <= '0;
      rd_addr_q    <= '0;
      rd_vld_q     <= 1'b0;
      min_q        <= EMPTY;
      min_addr_q   <= '0;
      best_valid_q <= 1'b0;
      best_addr_q  <= '0;
      best_cost_q  <= '0;
      q_we_q       <= 1'b0;
      empty_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      empty_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= SCAN;
            q_addr_q   <= '0;
            min_q      <= EMPTY;
            min_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        SCAN: begin
          rd_addr_q  <= q_addr_q;
          rd_vld_q   <= 1'b1;
          min_q      <= min_d;
          min_addr_q <= min_addr_d;
          if (q_addr_q == LAST_ADDR) begin
            state_q <= DRAIN;
          end else begin
            q_addr_q <= q_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          // Last slot's data arrives here; decide on the merged result.
          min_q      <= min_d;
          min_addr_q <= min_addr_d;
          if (min_d != EMPTY) begin
            state_q      <= OFFER;
            best_valid_q <= 1'b1;
            best_addr_q  <= min_addr_d;
            best_cost_q  <= min_d;
          end else begin
            state_q <= IDLE;
            empty_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        OFFER: begin
          if (bus.best_ready) begin
            state_q      <= POP;
            best_valid_q <= 1'b0;
            q_we_q       <= 1'b1;
            q_addr_q     <= best_addr_q;
          end
        end
        POP: begin
          state_q  <= IDLE;
          q_we_q   <= 1'b0;
          q_addr_q <= '0;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q_addr     = q_addr_q;
  assign bus.q_write_en = q_we_q;
  assign bus.q_wdata    = EMPTY;
  assign bus.best_valid = best_valid_q;
  assign bus.best_addr  = best_addr_q;
  assign bus.best_cost  = best_cost_q;
  assign bus.empty      = empty_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_min_cost_scanner.sv
// Self-checking bench for min_cost_scanner with a synchronous-read queue model.
module tb_min_cost_scanner;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  min_cost_scanner_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  min_cost_scanner #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] slots [16];
    int         stall;
    bit         early;
    bit         emp;
    logic [3:0] addr;
    logic [7:0] cost;
  } vec_t;

  typedef struct {
    bit         emp;
    logic [3:0] addr;
    logic [7:0] cost;
  } res_t;

  logic [7:0] mem [16];
  logic [7:0] ld_slots [16];
  logic       ld_req = 1'b0;
  int         wr_count = 0;
  res_t       sb [$];
  vec_t       vecs [7];
  int         total = 0;
  int         bad = 0;

  // Queue model: registered read, write port used only for pops.
  always @(posedge clk) begin
    if (ld_req) begin
      mem <= ld_slots;
    end else if (bus.q_write_en) begin
      mem[bus.q_addr] <= bus.q_wdata;
      wr_count <= wr_count + 1;
    end
    bus.q_data <= mem[bus.q_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    ld_slots = v.slots;
    ld_req = 1'b1;
    @(posedge clk); #1;
    ld_req = 1'b0;
  endtask

  task automatic do_scan(input res_t exp, input int stall, input bit early, input bit repulse);
    res_t r;
    int n;
    int w0;
    sb.push_back(exp);
    w0 = wr_count;
    bus.start = 1'b1;
    bus.best_ready = early;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    n = 0;
    while (n < 40 && !(bus.best_valid || bus.empty)) begin
      @(posedge clk); #1;
      n++;
      bus.start = repulse && (n == 5);
    end
    bus.start = 1'b0;
    chk("latency", 32'(n), 32'd17);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    r = sb.pop_front();
    if (n >= 40) begin
      bus.best_ready = 1'b0;
      return;
    end
    if (r.emp) begin
      chk("empty_pulse", 32'(bus.empty), 32'd1);
      chk("no_offer", 32'(bus.best_valid), 32'd0);
      chk("no_write_empty", 32'(wr_count - w0), 32'd0);
      @(posedge clk); #1;
      chk("empty_clear", 32'({bus.empty, bus.busy}), 32'd0);
    end else begin
      chk("best", 32'({bus.best_valid, bus.best_addr, bus.best_cost}), 32'({1'b1, r.addr, r.cost}));
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        chk("offer_hold", 32'({bus.best_valid, bus.best_addr, bus.best_cost, bus.q_write_en}),
            32'({1'b1, r.addr, r.cost, 1'b0}));
      end
      bus.best_ready = 1'b1;
      @(posedge clk); #1;
      bus.best_ready = 1'b0;
      chk("pop", 32'({bus.q_write_en, bus.best_valid, bus.q_addr, bus.q_wdata}),
          32'({1'b1, 1'b0, r.addr, 8'hFF}));
      @(posedge clk); #1;
      chk("pop_done", 32'({bus.q_write_en, bus.busy}), 32'd0);
      chk("slot_cleared", 32'(mem[r.addr]), 32'hFF);
      chk("one_write", 32'(wr_count - w0), 32'd1);
    end
  endtask

  initial begin : main
    res_t e;
    int   w0;

    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 16; i++) vecs[k].slots[i] = 8'hFF;
      vecs[k].stall = 0; vecs[k].early = 1'b0; vecs[k].emp = 1'b0;
      vecs[k].addr = '0; vecs[k].cost = '0;
    end
    vecs[0].emp = 1'b1;
    for (int i = 0; i < 16; i++) vecs[1].slots[i] = 8'(8'h10 + 3 * i);
    vecs[1].slots[9] = 8'h03; vecs[1].stall = 5; vecs[1].addr = 4'd9; vecs[1].cost = 8'h03;
    for (int i = 0; i < 16; i++) vecs[2].slots[i] = (i % 2 == 1) ? 8'hFF : 8'(8'h20 + i);
    vecs[2].slots[4] = 8'h05; vecs[2].slots[12] = 8'h05; vecs[2].early = 1'b1;
    vecs[2].addr = 4'd4; vecs[2].cost = 8'h05;
    vecs[3].slots[15] = 8'h00; vecs[3].stall = 2; vecs[3].addr = 4'd15; vecs[3].cost = 8'h00;
    vecs[4].slots[0] = 8'hFE; vecs[4].stall = 1; vecs[4].addr = 4'd0; vecs[4].cost = 8'hFE;
    for (int i = 0; i < 16; i++) vecs[5].slots[i] = 8'(8'hF0 - i);
    vecs[5].addr = 4'd15; vecs[5].cost = 8'hE1;
    for (int i = 0; i < 16; i++) vecs[6].slots[i] = 8'h40;
    vecs[6].stall = 3; vecs[6].addr = 4'd0; vecs[6].cost = 8'h40;

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.best_ready = 1'b0;
    #12;
    chk("reset_state",
        32'({bus.busy, bus.best_valid, bus.q_write_en, bus.empty, bus.q_addr, bus.best_addr, bus.best_cost, bus.q_wdata}),
        32'({4'b0000, 4'h0, 4'h0, 8'h00, 8'hFF}));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      load(vecs[k]);
      e.emp = vecs[k].emp; e.addr = vecs[k].addr; e.cost = vecs[k].cost;
      do_scan(e, vecs[k].stall, vecs[k].early, 1'b0);
    end

    // Pop then rescan: slot 9 is gone, next lowest is slot 0 at 0x10.
    load(vecs[1]);
    e.emp = 1'b0; e.addr = 4'd9; e.cost = 8'h03;
    do_scan(e, 0, 1'b0, 1'b0);
    e.addr = 4'd0; e.cost = 8'h10;
    do_scan(e, 0, 1'b0, 1'b0);

    // start re-pulsed mid-scan is ignored.
    load(vecs[2]);
    e.addr = 4'd4; e.cost = 8'h05;
    do_scan(e, 1, 1'b0, 1'b1);

    // Reset in the middle of a scan aborts it without any write.
    load(vecs[1]);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    w0 = wr_count;
    rst_n = 1'b0;
    #1;
    chk("rst_abort",
        32'({bus.busy, bus.best_valid, bus.q_write_en, bus.empty, bus.q_addr, bus.best_addr, bus.best_cost, bus.q_wdata}),
        32'({4'b0000, 4'h0, 4'h0, 8'h00, 8'hFF}));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_write_after_rst", 32'(wr_count - w0), 32'd0);
    chk("idle_after_rst", 32'({bus.busy, bus.best_valid}), 32'd0);
    chk("slot9_intact", 32'(mem[9]), 32'h03);
    e.addr = 4'd9; e.cost = 8'h03;
    do_scan(e, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
